// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, instruction fetch handshake and retire counter
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_step,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        misaligned,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;

  assign next_pc = pc_q + pc_step;

  // run_q keeps the request low for the first cycle out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instret_d   = instret_q;
    mis_d       = mis_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        if (!run_q) begin
          if (RESET_PC[1:0] != 2'b00) begin
            state_d = S_FAULT;
            mis_d   = 1'b1;
          end
        end else begin
          imem_req = !stall;
          if (!stall && imem_ready) begin
            instr_d = imem_rdata;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          instret_d = instret_q + 32'd1;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            instr_d = NOP_INSTR;
            state_d = S_REQ;
          end else begin
            mis_d   = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        mis_d = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
        mis_d   = 1'b1;
      end
    endcase
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign misaligned = mis_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized and directed checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_step = 32'd4;
  logic        exec_done = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        misaligned;
  logic [31:0] instret;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_step(pc_step), .exec_done(exec_done),
    .stall(stall), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .misaligned(misaligned), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: out-of-reset flag, held instruction flag, fault flag and architectural values
  bit          m_run, m_held, m_fault;
  logic [31:0] m_pc, m_instr, m_ret;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_run = 0; m_held = 0; m_fault = 0;
    m_pc = 32'd0; m_instr = NOP; m_ret = 32'd0;
  endfunction

  function automatic void model_step();
    logic [31:0] nxt;
    if (!m_run) begin
      m_run = 1;
      if (m_pc % 4 != 0) m_fault = 1;
    end else if (m_fault) begin
    end else if (!m_held) begin
      if (!stall && imem_ready) begin
        m_instr = imem_rdata;
        m_held  = 1;
      end
    end else if (exec_done) begin
      nxt   = m_pc + pc_step;
      m_ret = m_ret + 1;
      if (nxt % 4 == 0) begin
        m_pc = nxt; m_instr = NOP; m_held = 0;
      end else begin
        m_fault = 1;
      end
    end
  endfunction

  function automatic void check_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_run && !m_held && !m_fault && !stall});
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_held && !m_fault});
    chk("instr", instr, m_instr);
    chk("misaligned", {31'd0, misaligned}, {31'd0, m_fault});
    chk("instret", instret, m_ret);
  endfunction

  task automatic cyc(input logic s, input logic r, input logic [31:0] rd,
                     input logic d, input logic [31:0] ps);
    stall = s; imem_ready = r; imem_rdata = rd; exec_done = d; pc_step = ps;
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // from a REQ state: fetch then execute with the step that lands on target
  task automatic goto_pc(input logic [31:0] target);
    cyc(0, 1, $urandom, 0, 4);
    cyc(0, 0, $urandom, 1, target - m_pc);
  endtask

  logic [31:0] st;
  int          fault_cnt;

  initial begin
    model_reset();
    @(negedge clk);
    reset_dut();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instret", instret, 32'h0);
    cyc(0, 1, $urandom, 0, 4);

    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      chk("seq_valid_lo", {31'd0, instr_valid}, 32'd0);
      cyc(0, 1, $urandom, 0, 4);
      chk("seq_valid_hi", {31'd0, instr_valid}, 32'd1);
      cyc(0, 0, $urandom, 1, 4);
    end
    chk("seq_instret", instret, 32'd3);
    chk("seq_addr_end", imem_addr, 32'hC);

    goto_pc(32'h100);
    chk("br_to_100", imem_addr, 32'h100);
    cyc(0, 1, $urandom, 0, 4);
    cyc(0, 0, $urandom, 1, 32'hFFFF_FFF0);
    chk("br_back", imem_addr, 32'h0F0);
    cyc(0, 1, $urandom, 0, 4);
    cyc(0, 0, $urandom, 1, 32'h30);
    chk("br_fwd", imem_addr, 32'h120);

    cyc(1, 0, $urandom, 0, 4);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    cyc(1, 1, 32'h1234_5678, 0, 4);
    chk("stall_no_latch", instr, NOP);
    cyc(0, 0, $urandom, 0, 4);
    cyc(0, 0, $urandom, 0, 4);
    chk("wait_addr", imem_addr, 32'h120);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 4);
    chk("wait_latch", instr, 32'hDEAD_BEEF);
    chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    cyc(0, 0, $urandom, 1, 4);

    fault_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       st = ($urandom & 32'hFFFF_FFFC) | 32'h2;
        1, 2:    st = $urandom & 32'hFFFF_FFFC;
        default: st = 32'd4;
      endcase
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom,
          $urandom_range(0, 1) == 1, st);
      if (m_fault) fault_cnt++;
      if (fault_cnt > 4) begin
        fault_cnt = 0;
        reset_dut();
      end
    end

    reset_dut();
    cyc(0, 1, $urandom, 0, 4);
    goto_pc(32'hFFFF_FFFC);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    goto_pc(32'h0000_0000);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_nofault", {31'd0, misaligned}, 32'd0);

    goto_pc(32'h40);
    cyc(0, 1, $urandom, 0, 4);
    cyc(0, 0, $urandom, 1, 32'h6);
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_pc", pc, 32'h40);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, $urandom, 1'($urandom), 4);
      chk("mis_noreq", {31'd0, imem_req}, 32'd0);
    end
    chk("mis_pc_held", pc, 32'h40);
    reset_dut();
    chk("mis_clr_pc", pc, 32'h0);
    chk("mis_clr_flag", {31'd0, misaligned}, 32'd0);
    cyc(0, 0, $urandom, 0, 4);

    goto_pc(32'h80);
    stall = 1'b0; imem_ready = 1'b0;
    #1;
    chk("mid_req_hi", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all();
    chk("mid_instr", instr, NOP);
    rst_n = 1'b1;
    cyc(0, 1, 32'hCAFE_F00D, 0, 4);
    cyc(0, 1, 32'hCAFE_F00D, 0, 4);
    chk("post_rst_fetch", instr, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
